// File: rtl/apb_initiator_cfg.sv
// APB4 initiator: split read/write valid-ready requests become one APB transfer at a time.
// Latency: accept at N, SETUP N+1, ACCESS N+2, ack N+3 with no wait states; +1 per wait state.
// Backpressure: request rdy only in IDLE; a pending ack blocks new grants until its rdy.
module apb_initiator_cfg #(
    parameter int         ADDR_WIDTH     = 16,
    parameter int         DATA_WIDTH     = 32,
    parameter logic [2:0] PROT           = 3'b000,
    parameter int         TIMEOUT_CYCLES = 256
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [ADDR_WIDTH-1:0]   wreq_addr,
    input  logic [DATA_WIDTH-1:0]   wreq_data,
    input  logic [DATA_WIDTH/8-1:0] wreq_strb,
    input  logic                    wreq_vld,
    output logic                    wreq_rdy,
    input  logic [ADDR_WIDTH-1:0]   rreq_addr,
    input  logic                    rreq_vld,
    output logic                    rreq_rdy,
    output logic [DATA_WIDTH-1:0]   rack_data,
    output logic                    rack_err,
    output logic                    rack_vld,
    input  logic                    rack_rdy,
    output logic                    wack_err,
    output logic                    wack_vld,
    input  logic                    wack_rdy,
    output logic [ADDR_WIDTH-1:0]   p_addr,
    output logic [2:0]              p_prot,
    output logic                    p_sel,
    output logic                    p_enable,
    output logic                    p_write,
    output logic [DATA_WIDTH-1:0]   p_wdata,
    output logic [DATA_WIDTH/8-1:0] p_strb,
    input  logic                    p_ready,
    input  logic                    p_slverr,
    input  logic [DATA_WIDTH-1:0]   p_rdata
);
    localparam int STRB_W = DATA_WIDTH / 8;
    localparam int CNT_W  = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic TIMEOUT_EN = (TIMEOUT_CYCLES > 0);
    localparam logic [CNT_W-1:0] CNT_LAST =
        (TIMEOUT_CYCLES > 0) ? CNT_W'(TIMEOUT_CYCLES - 1) : '0;

    typedef enum logic [1:0] {IDLE, SETUP, ACCESS, RESP} state_t;

    typedef struct packed {
        logic                  write;
        logic [ADDR_WIDTH-1:0] addr;
        logic [DATA_WIDTH-1:0] data;
        logic [STRB_W-1:0]     strb;
    } hold_t;

    state_t                state_q, state_d;
    hold_t                 hold_q;
    logic [CNT_W-1:0]      cnt_q;
    logic                  last_wr_q;
    logic                  rack_vld_q, wack_vld_q;
    logic                  rack_err_q, wack_err_q;
    logic [DATA_WIDTH-1:0] rack_data_q;
    logic                  grant_w, grant_r;
    logic                  done, abort;

    always_comb begin
        state_d = state_q;
        grant_w = 1'b0;
        grant_r = 1'b0;
        done    = 1'b0;
        abort   = 1'b0;
        case (state_q)
            IDLE: begin
                // On a tie, the type not granted last wins.
                grant_w = wreq_vld && (!rreq_vld || !last_wr_q);
                grant_r = rreq_vld && (!wreq_vld || last_wr_q);
                if (grant_w || grant_r) state_d = SETUP;
            end
            SETUP: state_d = ACCESS;
            ACCESS: begin
                done  = p_ready;
                abort = !p_ready && TIMEOUT_EN && (cnt_q == CNT_LAST);
                if (done || abort) state_d = RESP;
            end
            RESP: begin
                if ((rack_vld_q && rack_rdy) || (wack_vld_q && wack_rdy)) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            hold_q      <= '0;
            cnt_q       <= '0;
            last_wr_q   <= 1'b0;
            rack_vld_q  <= 1'b0;
            wack_vld_q  <= 1'b0;
            rack_err_q  <= 1'b0;
            wack_err_q  <= 1'b0;
            rack_data_q <= '0;
        end else begin
            state_q <= state_d;

            if (grant_w) begin
                hold_q.write <= 1'b1;
                hold_q.addr  <= wreq_addr;
                hold_q.data  <= wreq_data;
                hold_q.strb  <= wreq_strb;
                last_wr_q    <= 1'b1;
            end else if (grant_r) begin
                hold_q.write <= 1'b0;
                hold_q.addr  <= rreq_addr;
                hold_q.data  <= '0;
                hold_q.strb  <= '0;
                last_wr_q    <= 1'b0;
            end

            if (state_q == SETUP) begin
                cnt_q <= '0;
            end else if (state_q == ACCESS && !p_ready && cnt_q != CNT_LAST) begin
                cnt_q <= cnt_q + CNT_W'(1);
            end

            // p_slverr only matters on the p_ready cycle; an abort always reports error.
            if (done || abort) begin
                if (hold_q.write) begin
                    wack_vld_q <= 1'b1;
                    wack_err_q <= abort | (done & p_slverr);
                end else begin
                    rack_vld_q  <= 1'b1;
                    rack_err_q  <= abort | (done & p_slverr);
                    rack_data_q <= abort ? '0 : p_rdata;
                end
            end

            if (rack_vld_q && rack_rdy) rack_vld_q <= 1'b0;
            if (wack_vld_q && wack_rdy) wack_vld_q <= 1'b0;
        end
    end

    assign wreq_rdy  = grant_w;
    assign rreq_rdy  = grant_r;
    assign rack_vld  = rack_vld_q;
    assign rack_err  = rack_err_q;
    assign rack_data = rack_data_q;
    assign wack_vld  = wack_vld_q;
    assign wack_err  = wack_err_q;

    assign p_sel    = (state_q == SETUP) || (state_q == ACCESS);
    assign p_enable = (state_q == ACCESS);
    assign p_write  = p_sel && hold_q.write;
    assign p_addr   = hold_q.addr;
    assign p_prot   = PROT;
    assign p_wdata  = p_sel ? hold_q.data : '0;
    assign p_strb   = p_sel ? hold_q.strb : '0;

endmodule
